iob_asym_fifo_ctrl: RTL and testbench

IOB_ASYM_FIFO_CTRL -- requirements
Module: iob_asym_fifo_ctrl

---
 rtl/iob_asym_fifo_ctrl.sv | 153 +++++++++++++++
 tb/tb_iob_asym_fifo_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_asym_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// iob_asym_fifo_ctrl
//
// Purpose:
//   Pointer/flag controller for a FIFO whose write and read ports have
//   different widths. The data itself lives in an external asymmetric RAM.
//   Occupancy is kept in narrow words, where N = min(W_DATA_W, R_DATA_W).
//   One write word is WR narrow words and one read word is RR narrow words.
//   The RAM is expected to place the lowest narrow slice of a wide word at
//   the lowest narrow address (little-endian), and to have a read latency of
//   one cycle.
//
// Optional feature:
//   Define IOB_ASYM_FIFO_ALMOST_EN to add the registered almost_full and
//   almost_empty outputs. Without the macro those ports and their logic are
//   absent, and everything else behaves the same.
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   w_en / w_data   push request and push data (W_DATA_W)
//   w_full          a whole write word cannot fit
//   r_en / r_data   pop request and pop data (R_DATA_W, valid 1 cycle after pop)
//   r_empty         no complete read word is stored
//   level           occupancy in narrow words (ADDR_W+1 bits)
//   ext_mem_w_*     RAM write port (enable, W_AW-bit address, data)
//   ext_mem_r_*     RAM read port (enable, R_AW-bit address, data in)
//   almost_full     (macro only) level >= 2**ADDR_W - ALMOST_TH
//   almost_empty    (macro only) level <= ALMOST_TH
// -----------------------------------------------------------------------------
module iob_asym_fifo_ctrl #(
    parameter int W_DATA_W  = 16,
    parameter int R_DATA_W  = 8,
    parameter int ADDR_W    = 7,
    parameter int ALMOST_TH = 4,
    // Derived geometry; not meant to be overridden.
    localparam int N    = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W,
    localparam int WR   = W_DATA_W / N,
    localparam int RR   = R_DATA_W / N,
    localparam int W_AW = ADDR_W - $clog2(WR),
    localparam int R_AW = ADDR_W - $clog2(RR)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_empty,
    output logic [ADDR_W:0]     level,
    output logic                ext_mem_w_en,
    output logic [W_AW-1:0]     ext_mem_w_addr,
    output logic [W_DATA_W-1:0] ext_mem_w_data,
    output logic                ext_mem_r_en,
    output logic [R_AW-1:0]     ext_mem_r_addr,
    input  logic [R_DATA_W-1:0] ext_mem_r_data
`ifdef IOB_ASYM_FIFO_ALMOST_EN
    ,
    output logic                almost_full,
    output logic                almost_empty
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W:0] WR_L    = (ADDR_W + 1)'(WR);
    localparam logic [ADDR_W:0] RR_L    = (ADDR_W + 1)'(RR);
    // Full as soon as fewer than WR narrow slots remain free.
    localparam logic [ADDR_W:0] FULL_TH = (ADDR_W + 1)'(DEPTH - WR);

    localparam logic [W_AW-1:0] W_ONE = 1;
    localparam logic [R_AW-1:0] R_ONE = 1;

    logic [W_AW-1:0] r_wptr;
    logic [R_AW-1:0] r_rptr;
    logic [ADDR_W:0] r_level;
    logic            r_w_full;
    logic            r_r_empty;

    logic            w_push;
    logic            w_pop;
    logic [ADDR_W:0] w_level_next;

    // Acceptance uses the registered flags only, so a simultaneous pop never
    // makes room for a push in the same cycle (and vice versa).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_push       = w_en && !r_w_full && !rst;
        w_pop        = r_en && !r_r_empty && !rst;
        w_level_next = r_level;
        // Add before subtract: an accepted push leaves level <= DEPTH, so the
        // intermediate never wraps.
        if (w_push) w_level_next = w_level_next + WR_L;
        if (w_pop)  w_level_next = w_level_next - RR_L;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_w_full  <= 1'b0;
            r_r_empty <= 1'b1;
        end else begin
            // Pointers are exactly W_AW/R_AW bits wide, so they wrap at the
            // top of memory with no extra cycle.
            if (w_push) r_wptr <= r_wptr + W_ONE;
            if (w_pop)  r_rptr <= r_rptr + R_ONE;
            r_level   <= w_level_next;
            r_w_full  <= (w_level_next > FULL_TH);
            r_r_empty <= (w_level_next < RR_L);
        end
    end

`ifdef IOB_ASYM_FIFO_ALMOST_EN
    localparam logic [ADDR_W:0] AF_TH = (ADDR_W + 1)'(DEPTH - ALMOST_TH);
    localparam logic [ADDR_W:0] AE_TH = (ADDR_W + 1)'(ALMOST_TH);

    logic r_almost_full;
    logic r_almost_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_level_next >= AF_TH);
            r_almost_empty <= (w_level_next <= AE_TH);
        end
    end

    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
`endif

    // RAM strobes are combinational so the access lands in the accept cycle.
    assign ext_mem_w_en   = w_push;
    assign ext_mem_w_addr = r_wptr;
    assign ext_mem_w_data = w_data;
    assign ext_mem_r_en   = w_pop;
    assign ext_mem_r_addr = r_rptr;

    // Read data comes straight from the RAM's registered output.
    assign r_data  = ext_mem_r_data;
    assign level   = r_level;
    assign w_full  = r_w_full;
    assign r_empty = r_r_empty;

endmodule

// File: tb/tb_iob_asym_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iob_asym_fifo_ctrl
//
// Instance A uses the default geometry (16-bit write, 8-bit read, 128 narrow
// words). Instance B uses 8-bit write, 32-bit read. Each instance is backed
// by a small asymmetric RAM model with one cycle of read latency. Expected
// values come from hand-computed vector tables and from a queue-of-bytes
// reference model of the FIFO.
// -----------------------------------------------------------------------------
module tb_iob_asym_fifo_ctrl;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- instance A: 16 -> 8 ----------------
    logic        a_rst, a_w_en, a_r_en;
    logic [15:0] a_w_data;
    logic        a_w_full, a_r_empty;
    logic [7:0]  a_r_data, a_level;
    logic        a_mw_en, a_mr_en;
    logic [5:0]  a_mw_addr;
    logic [15:0] a_mw_data;
    logic [6:0]  a_mr_addr;
    logic [7:0]  a_mr_data;
`ifdef IOB_ASYM_FIFO_ALMOST_EN
    logic        a_af, a_ae;
`endif

    iob_asym_fifo_ctrl u_a (
        .clk(clk), .rst(a_rst),
        .w_en(a_w_en), .w_data(a_w_data), .w_full(a_w_full),
        .r_en(a_r_en), .r_data(a_r_data), .r_empty(a_r_empty),
        .level(a_level),
        .ext_mem_w_en(a_mw_en), .ext_mem_w_addr(a_mw_addr), .ext_mem_w_data(a_mw_data),
        .ext_mem_r_en(a_mr_en), .ext_mem_r_addr(a_mr_addr), .ext_mem_r_data(a_mr_data)
`ifdef IOB_ASYM_FIFO_ALMOST_EN
        , .almost_full(a_af), .almost_empty(a_ae)
`endif
    );

    logic [7:0] mem_a [128];
    always @(posedge clk) begin
        if (a_mw_en) begin
            mem_a[{a_mw_addr, 1'b0}] <= a_mw_data[7:0];
            mem_a[{a_mw_addr, 1'b1}] <= a_mw_data[15:8];
        end
        if (a_mr_en) a_mr_data <= mem_a[a_mr_addr];
    end

    // ---------------- instance B: 8 -> 32 ----------------
    logic        b_rst, b_w_en, b_r_en;
    logic [7:0]  b_w_data;
    logic        b_w_full, b_r_empty;
    logic [31:0] b_r_data;
    logic [7:0]  b_level;
    logic        b_mw_en, b_mr_en;
    logic [6:0]  b_mw_addr;
    logic [7:0]  b_mw_data;
    logic [4:0]  b_mr_addr;
    logic [31:0] b_mr_data;
`ifdef IOB_ASYM_FIFO_ALMOST_EN
    logic        b_af, b_ae;
`endif

    iob_asym_fifo_ctrl #(.W_DATA_W(8), .R_DATA_W(32)) u_b (
        .clk(clk), .rst(b_rst),
        .w_en(b_w_en), .w_data(b_w_data), .w_full(b_w_full),
        .r_en(b_r_en), .r_data(b_r_data), .r_empty(b_r_empty),
        .level(b_level),
        .ext_mem_w_en(b_mw_en), .ext_mem_w_addr(b_mw_addr), .ext_mem_w_data(b_mw_data),
        .ext_mem_r_en(b_mr_en), .ext_mem_r_addr(b_mr_addr), .ext_mem_r_data(b_mr_data)
`ifdef IOB_ASYM_FIFO_ALMOST_EN
        , .almost_full(b_af), .almost_empty(b_ae)
`endif
    );

    logic [7:0] mem_b [128];
    always @(posedge clk) begin
        if (b_mw_en) mem_b[b_mw_addr] <= b_mw_data;
        if (b_mr_en) b_mr_data <= {mem_b[{b_mr_addr, 2'd3}], mem_b[{b_mr_addr, 2'd2}],
                                   mem_b[{b_mr_addr, 2'd1}], mem_b[{b_mr_addr, 2'd0}]};
    end

    // Combinational RAM-port values observed mid-cycle, before the edge.
    logic        obs_wme, obs_rme;
    logic [6:0]  obs_waddr, obs_raddr;
    logic [15:0] obs_wdata;

    // Called at a falling edge: drive, sample strobes, cross one rising edge,
    // return at the next falling edge with registered outputs settled.
    task automatic cyc_a(input logic rst_v, input logic we, input logic [15:0] wd, input logic re);
        a_rst = rst_v; a_w_en = we; a_w_data = wd; a_r_en = re;
        #1;
        obs_wme   = a_mw_en;
        obs_rme   = a_mr_en;
        obs_waddr = {1'b0, a_mw_addr};
        obs_raddr = a_mr_addr;
        obs_wdata = a_mw_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc_b(input logic rst_v, input logic we, input logic [7:0] wd, input logic re);
        b_rst = rst_v; b_w_en = we; b_w_data = wd; b_r_en = re;
        #1;
        obs_wme = b_mw_en;
        obs_rme = b_mr_en;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [15:0] wd;
        logic        re;
        logic [7:0]  lvl;
        logic        emp;
        logic        full;
        logic        wme;
        logic        rme;
        logic        chk_rd;
        logic [7:0]  rd;
    } vec_t;

    vec_t vecs [15];

    // Reference model: FIFO contents as a queue of narrow bytes.
    logic [7:0] q [$];
    int         wr_words, rd_words;

    initial begin
        a_rst = 1'b1; a_w_en = 1'b0; a_w_data = '0; a_r_en = 1'b0;
        b_rst = 1'b1; b_w_en = 1'b0; b_w_data = '0; b_r_en = 1'b0;

        //           rst   we    wd        re    lvl   emp   full  wme   rme   chkrd rd
        vecs[0]  = '{1'b1, 1'b1, 16'hAAAA, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 16'hBEEF, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hEF};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hBE};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 16'h1234, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 16'h5678, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h34};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h78};
        vecs[9]  = '{1'b0, 1'b1, 16'h0A0B, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 16'h0C0D, 1'b0, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 1'b1, 16'h0E0F, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 1'b1, 16'hCAFE, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFE};

        @(negedge clk);

        // ---------- table-driven vectors on A ----------
        for (int i = 0; i < 15; i++) begin
            cyc_a(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].re);
            check($sformatf("vec%0d mem_w_en", i), 32'(obs_wme), 32'(vecs[i].wme));
            check($sformatf("vec%0d mem_r_en", i), 32'(obs_rme), 32'(vecs[i].rme));
            check($sformatf("vec%0d level", i), 32'(a_level), 32'(vecs[i].lvl));
            check($sformatf("vec%0d r_empty", i), 32'(a_r_empty), 32'(vecs[i].emp));
            check($sformatf("vec%0d w_full", i), 32'(a_w_full), 32'(vecs[i].full));
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d r_data", i), 32'(a_r_data), 32'(vecs[i].rd));
        end

        // ---------- fill to full, overflow attempt, full push+pop, wrap ----------
        cyc_a(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            cyc_a(1'b0, 1'b1, {8'(2 * i + 1), 8'(2 * i)}, 1'b0);
            check($sformatf("fill%0d mem_w_en", i), 32'(obs_wme), 32'd1);
            check($sformatf("fill%0d w_full", i), 32'(a_w_full), (i == 63) ? 32'd1 : 32'd0);
        end
        check("fill level", 32'(a_level), 32'd128);
        cyc_a(1'b0, 1'b1, 16'hDEAD, 1'b0);
        check("overflow mem_w_en", 32'(obs_wme), 32'd0);
        check("overflow level", 32'(a_level), 32'd128);
        // Full: push refused, pop taken. One free slot cannot hold a 2-byte word.
        cyc_a(1'b0, 1'b1, 16'hDEAD, 1'b1);
        check("fullrw mem_w_en", 32'(obs_wme), 32'd0);
        check("fullrw mem_r_en", 32'(obs_rme), 32'd1);
        check("fullrw level", 32'(a_level), 32'd127);
        check("fullrw w_full", 32'(a_w_full), 32'd1);
        check("fullrw r_data", 32'(a_r_data), 32'h00);
        cyc_a(1'b0, 1'b0, '0, 1'b1);
        check("126 level", 32'(a_level), 32'd126);
        check("126 w_full", 32'(a_w_full), 32'd0);
        cyc_a(1'b0, 1'b1, 16'h8180, 1'b0);
        check("wrap write addr", 32'(obs_waddr), 32'd0);
        check("wrap level", 32'(a_level), 32'd128);
        for (int k = 0; k < 128; k++) begin
            cyc_a(1'b0, 1'b0, '0, 1'b1);
            check($sformatf("drain%0d r_data", k), 32'(a_r_data), 32'((k + 2) & 8'hFF));
        end
        check("drain level", 32'(a_level), 32'd0);
        check("drain r_empty", 32'(a_r_empty), 32'd1);

        // ---------- B: 8-bit writes gathered into a 32-bit read ----------
        cyc_b(1'b1, 1'b0, '0, 1'b0);
        check("B reset r_empty", 32'(b_r_empty), 32'd1);
        cyc_b(1'b0, 1'b1, 8'h11, 1'b0);
        check("B push1 r_empty", 32'(b_r_empty), 32'd1);
        cyc_b(1'b0, 1'b1, 8'h22, 1'b0);
        check("B push2 r_empty", 32'(b_r_empty), 32'd1);
        cyc_b(1'b0, 1'b1, 8'h33, 1'b1);
        check("B early pop mem_r_en", 32'(obs_rme), 32'd0);
        check("B push3 r_empty", 32'(b_r_empty), 32'd1);
        cyc_b(1'b0, 1'b1, 8'h44, 1'b0);
        check("B push4 r_empty", 32'(b_r_empty), 32'd0);
        check("B push4 level", 32'(b_level), 32'd4);
        cyc_b(1'b0, 1'b0, '0, 1'b1);
        check("B pop mem_r_en", 32'(obs_rme), 32'd1);
        check("B pop r_data", b_r_data, 32'h44332211);
        check("B pop level", 32'(b_level), 32'd0);
        check("B pop r_empty", 32'(b_r_empty), 32'd1);

        // ---------- randomized run on A against the queue model ----------
        cyc_a(1'b1, 1'b0, '0, 1'b0);
        q.delete();
        wr_words = 0;
        rd_words = 0;
        for (int i = 0; i < 3000; i++) begin
            int          ph, p_push, p_pop;
            logic        rv, we, re, acc_push, acc_pop;
            logic [15:0] wd;
            logic [7:0]  exp_rd;

            check("rnd level", 32'(a_level), 32'(q.size()));
            check("rnd w_full", 32'(a_w_full), 32'(q.size() > 126));
            check("rnd r_empty", 32'(a_r_empty), 32'(q.size() < 1));
`ifdef IOB_ASYM_FIFO_ALMOST_EN
            check("rnd almost_full", 32'(a_af), 32'(q.size() >= 124));
            check("rnd almost_empty", 32'(a_ae), 32'(q.size() <= 4));
`endif
            ph     = (i / 250) % 4;
            p_push = (ph == 0) ? 90 : (ph == 1) ? 30 : (ph == 2) ? 60 : 50;
            p_pop  = (ph == 0) ? 30 : (ph == 1) ? 90 : (ph == 2) ? 40 : 50;
            rv = ($urandom_range(299) == 0);
            we = ($urandom_range(99) < p_push);
            re = ($urandom_range(99) < p_pop);
            wd = 16'($urandom);

            acc_push = we && !rv && (q.size() <= 126);
            acc_pop  = re && !rv && (q.size() >= 1);

            cyc_a(rv, we, wd, re);
            check("rnd mem_w_en", 32'(obs_wme), 32'(acc_push));
            check("rnd mem_r_en", 32'(obs_rme), 32'(acc_pop));
            if (acc_push) begin
                check("rnd w_addr", 32'(obs_waddr), 32'(wr_words % 64));
                check("rnd w_data", 32'(obs_wdata), 32'(wd));
            end
            if (acc_pop) check("rnd r_addr", 32'(obs_raddr), 32'(rd_words % 128));

            if (rv) begin
                q.delete();
                wr_words = 0;
                rd_words = 0;
            end else begin
                if (acc_pop) begin
                    exp_rd = q.pop_front();
                    rd_words++;
                    check("rnd r_data", 32'(a_r_data), 32'(exp_rd));
                end
                if (acc_push) begin
                    q.push_back(wd[7:0]);
                    q.push_back(wd[15:8]);
                    wr_words++;
                end
            end
        end
        check("rnd final level", 32'(a_level), 32'(q.size()));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
